// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock-gate controller: detects sustained idleness, drains the cluster, gates and re-wakes its clock.
// Optional gated-cycle counter enabled by defining CLUSTER_CLK_GATE_CNT_EN.
module cluster_clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        test_mode_i,
    input  logic        busy_i,
    input  logic        wake_req_i,
    input  logic        gate_allow_i,
    output logic        drain_req_o,
    input  logic        drain_ack_i,
    output logic        clk_en_o,
    output logic        gated_o,
    output logic        wake_ack_o,
    input  logic        cnt_clr_i,
    output logic [31:0] gated_cycles_o
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_IDLE_CNT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_GATED    = 3'd3,
        ST_WAKE     = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WAKE_LOAD = CNT_WIDTH'(WAKE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 idle;

    logic clk_en_reg, clk_en_next;
    logic gated_reg, gated_next;
    logic drain_req_reg, drain_req_next;
    logic wake_ack_reg, wake_ack_next;

    assign idle = !busy_i && !wake_req_i && gate_allow_i && !test_mode_i;

    // State and counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; unknown encodings fall back to RUN
    always_comb begin
        state_next = ST_RUN;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (idle) begin
                    state_next = ST_IDLE_CNT;
                    cnt_next   = IDLE_LOAD;
                end
            end
            ST_IDLE_CNT: begin
                if (!idle) begin
                    state_next = ST_RUN;
                end else if (cnt_reg == '0) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_IDLE_CNT;
                    cnt_next   = cnt_reg - CNT_ONE;
                end
            end
            ST_DRAIN: begin
                // An abort beats a simultaneous acknowledge
                if (!idle) begin
                    state_next = ST_RUN;
                end else if (drain_ack_i) begin
                    state_next = ST_GATED;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_GATED: begin
                if (!idle) begin
                    state_next = ST_WAKE;
                    cnt_next   = WAKE_LOAD;
                end else begin
                    state_next = ST_GATED;
                end
            end
            ST_WAKE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_WAKE;
                    cnt_next   = cnt_reg - CNT_ONE;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        clk_en_next    = (state_next != ST_GATED);
        gated_next     = (state_next == ST_GATED);
        drain_req_next = (state_next == ST_DRAIN);
        wake_ack_next  = (state_reg == ST_WAKE) && (state_next == ST_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_en_reg    <= 1'b1;
            gated_reg     <= 1'b0;
            drain_req_reg <= 1'b0;
            wake_ack_reg  <= 1'b0;
        end else begin
            clk_en_reg    <= clk_en_next;
            gated_reg     <= gated_next;
            drain_req_reg <= drain_req_next;
            wake_ack_reg  <= wake_ack_next;
        end
    end

    assign clk_en_o    = clk_en_reg;
    assign gated_o     = gated_reg;
    assign drain_req_o = drain_req_reg;
    assign wake_ack_o  = wake_ack_reg;

`ifdef CLUSTER_CLK_GATE_CNT_EN
    logic [31:0] gated_cnt_reg;

    // Saturating count of cycles spent gated; clear has priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gated_cnt_reg <= '0;
        end else if (cnt_clr_i) begin
            gated_cnt_reg <= '0;
        end else if ((state_reg == ST_GATED) && (gated_cnt_reg != 32'hFFFF_FFFF)) begin
            gated_cnt_reg <= gated_cnt_reg + 32'd1;
        end
    end

    assign gated_cycles_o = gated_cnt_reg;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign gated_cycles_o = '0;
`endif

endmodule
